pipelined_adder_tree: RTL and testbench

Parametrised, pipelined, signed reduction tree for the PuDianNao datapath. It sums `NUM_IN` lanes with one register per tree level and applies per-lane masking. A valid/ready handshake carries backpressure through the pipeline. A final stage either emits each reduction or accumulates successive reductions into one result, so the block can serve dot products longer than `NUM_IN`.

---
 rtl/pipelined_adder_tree_pkg.sv | 37 +++
 rtl/pipelined_adder_tree_stage.sv | 41 ++++
 rtl/pipelined_adder_tree.sv | 167 ++++++++++++++++
 tb/tb_pipelined_adder_tree.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_tree_pkg.sv
// Shared types and helpers for the PuDianNao adder tree: operating mode,
// per-level sideband bundle, tree depth and saturation limits.
package pudiannao_pkg;

    typedef enum logic {
        REDUCE = 1'b0,
        ACCUM  = 1'b1
    } adder_mode_e;

    // Everything that rides alongside the partial sums through the tree.
    typedef struct packed {
        logic        valid;
        logic        last;
        adder_mode_e mode;
    } tree_side_t;

    localparam int SAT_FN_W = 128;

    function automatic int tree_levels(input int n);
        return $clog2(n);
    endfunction

    // Largest positive two's-complement value of width w, zero-extended.
    function automatic logic [SAT_FN_W-1:0] sat_max(input int w);
        logic [SAT_FN_W-1:0] one;
        one = {{(SAT_FN_W-1){1'b0}}, 1'b1};
        return (one << (w - 1)) - one;
    endfunction

    // Most negative value of width w; only the low w bits are meaningful.
    function automatic logic [SAT_FN_W-1:0] sat_min(input int w);
        logic [SAT_FN_W-1:0] one;
        one = {{(SAT_FN_W-1){1'b0}}, 1'b1};
        return one << (w - 1);
    endfunction

endpackage

// File: rtl/pipelined_adder_tree_stage.sv
// One tree level: adds adjacent lane pairs into a one-bit-wider register and
// carries the sideband bundle; the whole level holds while en is low.
module adder_tree_stage
    import pudiannao_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int IN_W = 8
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  tree_side_t             in_side,
    input  logic signed [IN_W-1:0] in_data [N_IN-1:0],
    output tree_side_t             out_side,
    output logic signed [IN_W:0]   out_data [N_IN/2-1:0]
);

    localparam int N_OUT = N_IN / 2;

    tree_side_t             r_side;
    logic signed [IN_W:0]   r_sum [N_OUT-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_side <= '0;
            for (int i = 0; i < N_OUT; i++) begin
                r_sum[i] <= '0;
            end
        end else if (en) begin
            r_side <= in_side;
            for (int i = 0; i < N_OUT; i++) begin
                r_sum[i] <= {in_data[2*i][IN_W-1],   in_data[2*i]}
                          + {in_data[2*i+1][IN_W-1], in_data[2*i+1]};
            end
        end
    end

    assign out_side = r_side;
    assign out_data = r_sum;

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined signed reduction tree with lane masking and a REDUCE/ACCUM final stage.
// Define PUDIANNAO_ADDER_TREE_SAT_EN for a saturating final stage with out_ovf.
module pipelined_adder_tree
    import pudiannao_pkg::*;
#(
    parameter int NUM_IN = 16,
    parameter int WIDTH  = 32,
    parameter int ACC_W  = WIDTH + $clog2(NUM_IN) + 8
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] in_data [NUM_IN-1:0],
    input  logic [NUM_IN-1:0]       in_mask,
    input  logic                    in_mode,
    input  logic                    in_last,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_ovf,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int LEVELS = tree_levels(NUM_IN);
    localparam int SUM_W  = WIDTH + LEVELS;

    logic                    w_stall;
    logic                    w_advance;
    tree_side_t              w_rootSide;
    logic signed [SUM_W-1:0] w_treeSum;
    logic signed [ACC_W-1:0] w_sumExt;
    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W-1:0] w_addRes;

    tree_side_t              r_inSide;
    logic signed [WIDTH-1:0] r_lane [NUM_IN-1:0];
    logic                    r_outValid;
    logic signed [ACC_W-1:0] r_outData;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_open;

    // A held output freezes the entire pipe, so in_ready never looks at in_valid.
    assign w_stall   = r_outValid & ~out_ready;
    assign w_advance = ~w_stall;
    assign in_ready  = w_advance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inSide <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                r_lane[i] <= '0;
            end
        end else if (w_advance) begin
            r_inSide <= '{valid: in_valid, last: in_last, mode: adder_mode_e'(in_mode)};
            for (int i = 0; i < NUM_IN; i++) begin
                r_lane[i] <= in_mask[i] ? in_data[i] : '0;
            end
        end
    end

    // Level k consumes level k-1's registers directly through the generate hierarchy.
    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int N_K = NUM_IN >> k;
        localparam int W_K = WIDTH + k;

        tree_side_t            w_sideIn;
        tree_side_t            w_sideOut;
        logic signed [W_K-1:0] w_in [N_K-1:0];
        logic signed [W_K:0]   w_q  [N_K/2-1:0];

        if (k == 0) begin : g_src
            assign w_sideIn = r_inSide;
            assign w_in     = r_lane;
        end else begin : g_src
            assign w_sideIn = g_level[k-1].w_sideOut;
            assign w_in     = g_level[k-1].w_q;
        end

        adder_tree_stage #(
            .N_IN (N_K),
            .IN_W (W_K)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .en       (w_advance),
            .in_side  (w_sideIn),
            .in_data  (w_in),
            .out_side (w_sideOut),
            .out_data (w_q)
        );

        if (k == LEVELS - 1) begin : g_root
            assign w_rootSide = w_sideOut;
            assign w_treeSum  = w_q[0];
        end
    end

    assign w_sumExt = ACC_W'(w_treeSum);
    assign w_base   = r_open ? r_acc : '0;

`ifdef PUDIANNAO_ADDER_TREE_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));

    logic signed [ACC_W:0] w_wide;
    logic                  w_satEvent;
    logic                  r_outOvf;
    logic                  r_accOvf;

    // One guard bit exposes overflow; the guard bit's sign picks the rail.
    assign w_wide     = {w_base[ACC_W-1], w_base} + {w_sumExt[ACC_W-1], w_sumExt};
    assign w_satEvent = w_wide[ACC_W] ^ w_wide[ACC_W-1];
    assign w_addRes   = !w_satEvent ? w_wide[ACC_W-1:0]
                                    : (w_wide[ACC_W] ? SAT_MIN : SAT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outOvf <= 1'b0;
            r_accOvf <= 1'b0;
        end else if (w_advance && w_rootSide.valid) begin
            if (w_rootSide.mode == REDUCE) begin
                r_outOvf <= 1'b0;
            end else if (w_rootSide.last) begin
                r_outOvf <= (r_open & r_accOvf) | w_satEvent;
                r_accOvf <= 1'b0;
            end else begin
                r_accOvf <= (r_open & r_accOvf) | w_satEvent;
            end
        end
    end

    assign out_ovf = r_outOvf;
`else
    assign w_addRes = w_base + w_sumExt;
    assign out_ovf  = 1'b0;
`endif

    // REDUCE beats bypass the accumulator, so an open group survives them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_acc      <= '0;
            r_open     <= 1'b0;
        end else if (w_advance) begin
            r_outValid <= 1'b0;
            if (w_rootSide.valid) begin
                if (w_rootSide.mode == REDUCE) begin
                    r_outValid <= 1'b1;
                    r_outData  <= w_sumExt;
                end else if (w_rootSide.last) begin
                    r_outValid <= 1'b1;
                    r_outData  <= w_addRes;
                    r_acc      <= '0;
                    r_open     <= 1'b0;
                end else begin
                    r_acc      <= w_addRes;
                    r_open     <= 1'b1;
                end
            end
        end
    end

    assign out_valid = r_outValid;
    assign out_data  = r_outData;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Self-checking bench for pipelined_adder_tree (NUM_IN=16, WIDTH=8, ACC_W=12):
// directed scenarios plus randomized traffic scored against an arithmetic model.
module tb_pipelined_adder_tree;

    localparam int NUM_IN  = 16;
    localparam int WIDTH   = 8;
    localparam int ACC_W   = 12;
    localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
    localparam int ACC_MIN = -(1 << (ACC_W - 1));
    localparam int ACC_MOD = 1 << ACC_W;

    typedef struct {
        int data;
        bit ovf;
    } exp_t;

    logic                    clk;
    logic                    rst;
    logic signed [WIDTH-1:0] inData [NUM_IN-1:0];
    logic [NUM_IN-1:0]       inMask;
    logic                    inMode;
    logic                    inLast;
    logic                    inValid;
    logic                    inReady;
    logic signed [ACC_W-1:0] outData;
    logic                    outOvf;
    logic                    outValid;
    logic                    outReady;

    int   checks   = 0;
    int   failures = 0;
    int   stepNum  = 0;
    int   lo       = 0;
    int   hi       = 0;
    bit   randomReady  = 0;
    bit   lastAccepted = 0;
    bit   sawNotReady  = 0;
    bit   prevStall    = 0;
    logic signed [ACC_W-1:0] prevData;

    exp_t expQ[$];
    int   gotData[$];
    bit   gotOvf[$];
    bit   validTrace[$];

    int   mAcc  = 0;
    bit   mOpen = 0;
    bit   mOvf  = 0;

    pipelined_adder_tree #(
        .NUM_IN (NUM_IN),
        .WIDTH  (WIDTH),
        .ACC_W  (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (inData),
        .in_mask   (inMask),
        .in_mode   (inMode),
        .in_last   (inLast),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .out_data  (outData),
        .out_ovf   (outOvf),
        .out_valid (outValid),
        .out_ready (outReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference: masked lane sum, then the group rules with wrap or clamp.
    task automatic modelBeat();
        int sum;
        int t;
        bit ev;
        sum = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (inMask[i]) sum += int'(inData[i]);
        end
        if (!inMode) begin
            expQ.push_back('{data: sum, ovf: 1'b0});
        end else begin
            t  = (mOpen ? mAcc : 0) + sum;
            ev = 1'b0;
`ifdef PUDIANNAO_ADDER_TREE_SAT_EN
            if (t > ACC_MAX) begin
                t = ACC_MAX;
                ev = 1'b1;
            end else if (t < ACC_MIN) begin
                t = ACC_MIN;
                ev = 1'b1;
            end
`else
            t = ((t % ACC_MOD) + ACC_MOD) % ACC_MOD;
            if (t > ACC_MAX) t -= ACC_MOD;
`endif
            mOvf = (mOpen ? mOvf : 1'b0) | ev;
            if (inLast) begin
                expQ.push_back('{data: t, ovf: mOvf});
                mAcc  = 0;
                mOpen = 1'b0;
                mOvf  = 1'b0;
            end else begin
                mAcc  = t;
                mOpen = 1'b1;
            end
        end
    endtask

    // One clock: set out_ready, sample just after the falling edge, score, advance.
    task automatic step();
        bit accepted;
        bit taken;
        exp_t e;
        if (randomReady) outReady = ($urandom_range(0, 3) != 0);
        else             outReady = !(stepNum >= lo && stepNum < hi);
        #1;
        accepted = inValid && inReady;
        taken    = outValid && outReady;
        validTrace.push_back(outValid);
        if (!inReady) sawNotReady = 1'b1;
        if (prevStall) begin
            checkOutput("hold_valid", outValid, 1);
            checkOutput("hold_data", outData, prevData);
        end
        prevStall = outValid && !outReady;
        prevData  = outData;
        if (taken) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_out_valid", outValid, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("model_data", outData, e.data);
                checkOutput("model_ovf", outOvf, e.ovf);
                gotData.push_back(int'(outData));
                gotOvf.push_back(outOvf);
            end
        end
        if (accepted) modelBeat();
        lastAccepted = accepted;
        @(posedge clk);
        stepNum++;
        @(negedge clk);
    endtask

    task automatic sendCurrent();
        int n;
        n = 0;
        inValid = 1'b1;
        do begin
            step();
            n++;
        end while (!lastAccepted && n < 40);
        if (!lastAccepted) checkOutput("accept_timeout", lastAccepted, 1);
        inValid = 1'b0;
    endtask

    task automatic applyStimulus(input int base, input int inc, input logic [NUM_IN-1:0] mask,
                                 input logic mode, input logic last);
        for (int i = 0; i < NUM_IN; i++) inData[i] = WIDTH'(base + i * inc);
        inMask = mask;
        inMode = mode;
        inLast = last;
        sendCurrent();
    endtask

    task automatic idle(input int n);
        inValid = 1'b0;
        repeat (n) step();
    endtask

    task automatic drain();
        int n;
        n = 0;
        inValid = 1'b0;
        while (expQ.size() != 0 && n < 200) begin
            step();
            n++;
        end
        checkOutput("drain_empty", expQ.size(), 0);
        repeat (6) step();
    endtask

    task automatic clearLogs();
        gotData.delete();
        gotOvf.delete();
        validTrace.delete();
    endtask

    initial begin
        int f;
        int l;
        rst      = 1'b1;
        inValid  = 1'b0;
        inMode   = 1'b0;
        inLast   = 1'b0;
        inMask   = '0;
        outReady = 1'b1;
        for (int i = 0; i < NUM_IN; i++) inData[i] = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_out_valid", outValid, 0);
        checkOutput("rst_out_data", outData, 0);
        checkOutput("rst_out_ovf", outOvf, 0);
        checkOutput("rst_in_ready", inReady, 1);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] latency and single REDUCE");
        clearLogs();
        applyStimulus(1, 0, 16'hFFFF, 1'b0, 1'b0);
        idle(6);
        checkOutput("lat_not_before", validTrace[5], 0);
        checkOutput("lat_arrives", validTrace[6], 1);
        drain();
        checkOutput("reduce_ones_count", gotData.size(), 1);
        checkOutput("reduce_ones", gotData[0], 16);

        $display("[TB] back-to-back REDUCE");
        clearLogs();
        repeat (4) applyStimulus(1, 0, 16'hFFFF, 1'b0, 1'b0);
        drain();
        f = -1;
        l = -1;
        foreach (validTrace[j]) begin
            if (validTrace[j]) begin
                if (f < 0) f = j;
                l = j;
            end
        end
        checkOutput("b2b_count", gotData.size(), 4);
        checkOutput("b2b_span", l - f, 3);

        $display("[TB] REDUCE boundaries and mask");
        clearLogs();
        applyStimulus(-128, 0, 16'hFFFF, 1'b0, 1'b0);
        applyStimulus(0, 1, 16'h00FF, 1'b0, 1'b0);
        drain();
        checkOutput("reduce_min_count", gotData.size(), 2);
        checkOutput("reduce_min", gotData[0], -2048);
        checkOutput("reduce_mask", gotData[1], 28);

        $display("[TB] ACCUM group with bubble");
        clearLogs();
        applyStimulus(2, 0, 16'hFFFF, 1'b1, 1'b0);
        idle(1);
        applyStimulus(2, 0, 16'hFFFF, 1'b1, 1'b0);
        applyStimulus(2, 0, 16'hFFFF, 1'b1, 1'b1);
        drain();
        checkOutput("accum_count", gotData.size(), 1);
        checkOutput("accum_sum", gotData[0], 96);

        $display("[TB] REDUCE interleaved into open group");
        clearLogs();
        applyStimulus(2, 0, 16'hFFFF, 1'b1, 1'b0);
        applyStimulus(1, 0, 16'hFFFF, 1'b0, 1'b0);
        applyStimulus(2, 0, 16'hFFFF, 1'b1, 1'b0);
        idle(1);
        applyStimulus(2, 0, 16'hFFFF, 1'b1, 1'b1);
        drain();
        checkOutput("mix_count", gotData.size(), 2);
        checkOutput("mix_reduce", gotData[0], 16);
        checkOutput("mix_group", gotData[1], 96);

        $display("[TB] backpressure");
        clearLogs();
        sawNotReady = 1'b0;
        lo = stepNum + 6;
        hi = lo + 4;
        applyStimulus(1, 0, 16'hFFFF, 1'b0, 1'b0);
        idle(3);
        for (int v = 2; v <= 6; v++) applyStimulus(v, 0, 16'hFFFF, 1'b0, 1'b0);
        drain();
        checkOutput("bp_in_ready_dropped", sawNotReady, 1);
        checkOutput("bp_count", gotData.size(), 6);
        for (int v = 0; v < 6 && v < gotData.size(); v++) begin
            checkOutput("bp_order", gotData[v], 16 * (v + 1));
        end

        $display("[TB] saturation / wrap");
        clearLogs();
        applyStimulus(127, 0, 16'hFFFF, 1'b1, 1'b0);
        applyStimulus(127, 0, 16'hFFFF, 1'b1, 1'b1);
        drain();
        checkOutput("sat_count", gotData.size(), 1);
`ifdef PUDIANNAO_ADDER_TREE_SAT_EN
        checkOutput("sat_data", gotData[0], 2047);
        checkOutput("sat_ovf", gotOvf[0], 1);
`else
        checkOutput("wrap_data", gotData[0], -32);
        checkOutput("wrap_ovf", gotOvf[0], 0);
`endif

        $display("[TB] randomized traffic");
        clearLogs();
        randomReady = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                for (int i = 0; i < NUM_IN; i++) inData[i] = WIDTH'($urandom);
                inMask = NUM_IN'($urandom);
                inMode = 1'($urandom_range(0, 1));
                inLast = ($urandom_range(0, 2) == 0);
                sendCurrent();
            end
        end
        randomReady = 1'b0;
        drain();

        $display("[TB] reset mid-operation");
        clearLogs();
        applyStimulus(3, 0, 16'hFFFF, 1'b1, 1'b0);
        applyStimulus(5, 0, 16'hFFFF, 1'b0, 1'b0);
        applyStimulus(1, 0, 16'hFFFF, 1'b1, 1'b0);
        inValid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_out_valid", outValid, 0);
        checkOutput("mid_rst_out_data", outData, 0);
        checkOutput("mid_rst_out_ovf", outOvf, 0);
        checkOutput("mid_rst_in_ready", inReady, 1);
        expQ.delete();
        mAcc      = 0;
        mOpen     = 1'b0;
        mOvf      = 1'b0;
        prevStall = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clearLogs();
        applyStimulus(1, 0, 16'hFFFF, 1'b1, 1'b1);
        drain();
        checkOutput("post_rst_count", gotData.size(), 1);
        checkOutput("post_rst_sum", gotData[0], 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
